// File: rtl/add_pipe.sv
// add_pipe: parametrised pipelined ripple-carry adder with valid/ready handshake.
//
// The operands are split into STAGES segments of SEG = WIDTH/STAGES bits. Stage k
// adds segment k plus the carry registered by stage k-1. Upper operand bits are
// delayed alongside the partial sums. A single global advance signal stalls the
// whole pipeline under back-pressure. Bubbles are carried forward, not collapsed.
//
// Optional feature (macro ADD_PIPE_SUB_EN): adds input port 'sub'. When sub=1 the
// block computes a - b as a + ~b + 1, and c_in is ignored for that operation.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands this cycle (combinational)
//   a, b       WIDTH-bit operands
//   c_in       carry into bit 0
//   sub        (ADD_PIPE_SUB_EN only) subtract b from a
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        a + b + c_in modulo 2^WIDTH
//   c_out      carry out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
module add_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef ADD_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned SEGW = SEG + 1;
  localparam int unsigned LAST = STAGES - 1;

  // Per-stage registers
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;

  // Per-stage inputs and next values
  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];
  logic [WIDTH-1:0] nx_s [STAGES];
  logic             nx_c [STAGES];
  logic             nx_ovf;

  logic             adv;
  logic [WIDTH-1:0] b0;
  logic             c0;

  // Operand conditioning at the pipeline entry
`ifdef ADD_PIPE_SUB_EN
  assign b0 = sub ? ~b : b;
  assign c0 = sub | c_in;
`else
  assign b0 = b;
  assign c0 = c_in;
`endif

  // Global advance: every register loads together or holds together
  assign adv       = ~v_q[LAST] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign c_out     = c_q[LAST];
  assign ovf       = ovf_q;

  // Stage input selection: stage 0 from the ports, later stages from predecessor
  always_comb begin
    st_a[0] = a;
    st_b[0] = b0;
    st_s[0] = '0;
    st_c[0] = c0;
    st_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_s[k] = s_q[k-1];
      st_c[k] = c_q[k-1];
      st_v[k] = v_q[k-1];
    end
  end

  // Segment adders; overflow uses the carry into the MSB recovered from the sum bit
  always_comb begin
    logic [SEGW-1:0] seg;
    seg = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg = SEGW'(st_a[k][k*SEG +: SEG]) + SEGW'(st_b[k][k*SEG +: SEG]) + SEGW'(st_c[k]);
      nx_s[k] = st_s[k];
      nx_s[k][k*SEG +: SEG] = seg[SEG-1:0];
      nx_c[k] = seg[SEG];
    end
    nx_ovf = (nx_s[LAST][WIDTH-1] ^ st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1]) ^ nx_c[LAST];
  end

  // Stage registers; data only captured for valid slots so bubbles leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= st_v[k];
        if (st_v[k]) begin
          a_q[k] <= st_a[k];
          b_q[k] <= st_b[k];
          s_q[k] <= nx_s[k];
          c_q[k] <= nx_c[k];
        end
      end
      if (st_v[LAST]) begin
        ovf_q <= nx_ovf;
      end
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed and random checks of add_pipe against an arithmetic model.
module tb_add_pipe;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub_tb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int checks = 0;
  int errors = 0;
  int nres   = 0;
  logic [WIDTH+1:0] exp_q [$];   // {ovf, c_out, sum}

  always #5 clk = ~clk;

  add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef ADD_PIPE_SUB_EN
    .sub       (sub_tb),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: full-width arithmetic, signed overflow from operand/result signs
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci, input logic s);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] yy;
    logic             cc;
    logic             v;
    yy   = s ? ~y : y;
    cc   = s ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(cc);
    v    = (x[WIDTH-1] == yy[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {v, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic ci, input logic s, input logic ordy);
    in_valid  = v;
    a         = x;
    b         = y;
    c_in      = ci;
    sub_tb    = s;
    out_ready = ordy;
  endtask

  // One clock cycle: score any completed output, record any accepted input
  task automatic step();
    logic [WIDTH+1:0] e;
    #1;
    if (out_valid && out_ready) begin
      nres++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("stream_sum",   32'(sum),   32'(e[WIDTH-1:0]));
        chk("stream_c_out", 32'(c_out), 32'(e[WIDTH]));
        chk("stream_ovf",   32'(ovf),   32'(e[WIDTH+1]));
      end
    end
    if (in_valid && in_ready && !rst) exp_q.push_back(ref_add(a, b, c_in, sub_tb));
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic ci, input logic s, input logic [WIDTH-1:0] es,
                           input logic ec, input logic eo);
    int lat;
    drive(1'b1, x, y, ci, s, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(STAGES));
    chk({tag, "_sum"},     32'(sum),   32'(es));
    chk({tag, "_c_out"},   32'(c_out), 32'(ec));
    chk({tag, "_ovf"},     32'(ovf),   32'(eo));
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_sum",       32'(sum),       32'd0);
      chk("idle_in_ready",  32'(in_ready),  32'd1);
    end

    // Directed single operations
    single_op("carry_ripple", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    single_op("wrap",         16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    single_op("overflow",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Back-to-back random stream: one result per cycle once the pipe is full
    nres = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      step();
    end
    chk("stream_results_in_flight", 32'(nres), 32'(20 - STAGES));
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    drain();
    chk("stream_result_count", 32'(nres), 32'd20);
    chk("stream_queue_empty",  32'(exp_q.size()), 32'd0);

    // Back-pressure: stall 5 cycles with a valid result at the output
    nres = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      step();
    end
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b0, 1'b0);
      #1;
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum",       32'(sum),   32'(exp_q[0][WIDTH-1:0]));
      chk("bp_c_out",     32'(c_out), 32'(exp_q[0][WIDTH]));
      chk("bp_ovf",       32'(ovf),   32'(exp_q[0][WIDTH+1]));
      step();
    end
    chk("bp_no_result_during_stall", 32'(nres), 32'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    drain();
    chk("bp_result_count", 32'(nres), 32'd4);
    chk("bp_queue_empty",  32'(exp_q.size()), 32'd0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum",       32'(sum),       32'd0);
    chk("rst_c_out",     32'(c_out),     32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    nres = 0;
    single_op("post_rst", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step();
    chk("post_rst_result_count", 32'(nres), 32'd1);

`ifdef ADD_PIPE_SUB_EN
    single_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    single_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined ripple-carry adder. Successor to the team's fixed 4-bit combinational adder.
- Operands are split into STAGES equal segments. Each segment is added in its own pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on input and output, with back-pressure. Used in datapaths where a full-width combinational carry chain would miss timing.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); segment width SEG = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  a + b + c_in, modulo 2^WIDTH.
- c_out  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all stage valid bits 0, all data/carry registers 0. After reset: out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1.
- rst overrides everything. Asserting rst mid-operation discards all in-flight results; the next cycle matches the post-reset state.
- Global advance: adv = ~out_valid | out_ready. in_ready = adv (combinational; no dependence on in_valid).
- All stage registers load only when adv=1. When adv=0 every register holds: sum/c_out/ovf stay stable while out_valid=1 and out_ready=0.
- Stage 0 on accept (in_valid & in_ready):
  - adds a[SEG-1:0] + b[SEG-1:0] + c_in;
  - registers the SEG-bit partial sum and carry;
  - registers the remaining upper operand bits unchanged;
  - sets valid0 = 1.
- Stage 0 when adv=1 and no accept: valid0 <= 0; data contents are don't-care. Bubbles propagate; they are not collapsed.
- Stage k (1..STAGES-1): when adv=1, adds segment k of the delayed operands plus stage k-1 registered carry. Passes the lower partial sums and valid bit forward.
- The last stage drives sum, c_out, ovf and out_valid directly from registers. No combinational path from a/b to outputs.
- ovf is computed in the last stage from the carry into and out of bit WIDTH-1.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready=1. Throughput: 1 result/cycle.
- STAGES=1: single registered full-width adder, latency 1.
- Ordering: results leave in acceptance order, and every accepted operand pair produces exactly one result.
- Same cycle, out_valid=1 and out_ready=1 with a new input: the output is consumed and a new input accepted simultaneously.
- Arithmetic wrap-around is expected: all-ones + 1 gives sum=0, c_out=1.

Optional Feature:
- Macro: ADD_PIPE_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with a on accept.
  - sub=1 computes a - b as a + ~b + 1; c_in is ignored for that operation.
  - c_out=1 means no borrow (a >= b unsigned); ovf reflects signed subtraction overflow.
  - sub is pipelined alongside the operands only if needed for debug; results are otherwise identical in timing.
- Not defined: no sub port; addition only, as above.

Test Plan:
- Reset then idle, WIDTH=16 STAGES=4 -> out_valid=0, sum=0, in_ready=1 for 10 cycles.
- Single op a=16'h00FF, b=16'h0001, c_in=0, out_ready=1 -> after exactly 4 cycles out_valid=1, sum=16'h0100, c_out=0, ovf=0; carry ripples across segment boundary.
- Wrap/overflow:
  - a=16'hFFFF, b=16'h0000, c_in=1 -> sum=16'h0000, c_out=1, ovf=0.
  - a=16'h7FFF, b=16'h0001 -> sum=16'h8000, c_out=0, ovf=1.
- Back-to-back stream of 20 random pairs with out_ready=1 -> one result per cycle, in order, each matching a+b+c_in against a reference model.
- Back-pressure: hold out_ready=0 for 5 cycles while a result is valid -> in_ready=0, outputs stable and unchanged; on release, results resume in order with none lost or duplicated.
- Reset mid-stream with 3 ops in flight -> the cycle after rst, out_valid=0. The first post-reset op returns only its own result after 4 cycles.
- With ADD_PIPE_SUB_EN: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, c_out=0.
